// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch hazard controller for the ID stage of a 5-stage MIPS pipeline.
// Optional saturating stall-cycle counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int unsigned REG_ADDR_W          = 5,
  parameter int unsigned INSTR_W             = 32,
  parameter int unsigned LOAD_STALL_CYCLES   = 1,
  parameter int unsigned BRANCH_STALL_CYCLES = 1,
  parameter bit          ZERO_REG_EXEMPT     = 1'b1,
  parameter int unsigned CNT_W               = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic                  ex_mem_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_mem_rt,
  input  logic [INSTR_W-1:0]    if_id_instr,
  output logic                  hold_pc,
  output logic                  hold_if_id,
  output logic                  bubble_sel,
  output logic [1:0]            stall_state,
  output logic [CNT_W-1:0]      perf_load_stalls,
  output logic [CNT_W-1:0]      perf_branch_stalls
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_BRANCH  = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RS_LSB = RT_LSB + REG_ADDR_W;

  localparam logic [3:0] LOAD_A_CNT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] LOAD_B_CNT = 4'(LOAD_STALL_CYCLES - 2);
  localparam logic [3:0] BRANCH_CNT = 4'(BRANCH_STALL_CYCLES - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [REG_ADDR_W-1:0] rs, rt;
  logic [5:0]            opcode;
  logic                  hit_a, hit_b, br;
  logic                  accept;
  logic                  stall;
  logic                  unused_instr;

  assign rs           = if_id_instr[RS_LSB +: REG_ADDR_W];
  assign rt           = if_id_instr[RT_LSB +: REG_ADDR_W];
  assign opcode       = if_id_instr[INSTR_W-1 -: 6];
  assign unused_instr = ^if_id_instr;

  assign hit_a = id_ex_mem_read && (id_ex_rt == rs || id_ex_rt == rt)
                 && !(ZERO_REG_EXEMPT && id_ex_rt == '0);
  // An EX/MEM load only needs extra cycles when a load takes two or more to resolve.
  assign hit_b = (LOAD_STALL_CYCLES >= 2) && ex_mem_mem_read
                 && (ex_mem_rt == rs || ex_mem_rt == rt)
                 && !(ZERO_REG_EXEMPT && ex_mem_rt == '0);
  assign br    = (opcode == 6'b000100) || (opcode == 6'b000101);

  assign accept = (state_q == S_IDLE) || (state_q == S_RELEASE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_RELEASE: begin
        state_d = S_IDLE;
        if (hit_a) begin
          if (LOAD_STALL_CYCLES > 1) begin
            cnt_d   = LOAD_A_CNT;
            state_d = S_LOAD;
          end
        end else if (hit_b) begin
          if (LOAD_STALL_CYCLES > 2) begin
            cnt_d   = LOAD_B_CNT;
            state_d = S_LOAD;
          end
        end else if (br && state_q == S_IDLE) begin
          if (BRANCH_STALL_CYCLES > 1) begin
            cnt_d   = BRANCH_CNT;
            state_d = S_BRANCH;
          end else begin
            state_d = S_RELEASE;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
        else              state_d = S_IDLE;
      end
      S_BRANCH: begin
        if (cnt_q > 4'd1) cnt_d = cnt_q - 4'd1;
        else              state_d = S_RELEASE;
      end
    endcase
  end

  // Gated by rst so the holds drop the instant reset asserts, even with a hazard on the inputs.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = (state_q == S_LOAD) || (state_q == S_BRANCH)
              || (accept && (hit_a || hit_b || (br && state_q == S_IDLE)));
    end
  end

  assign hold_pc     = stall;
  assign hold_if_id  = stall;
  assign bubble_sel  = stall;
  assign stall_state = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic             load_cause, branch_cause;
  logic [CNT_W-1:0] perf_load_q, perf_load_d;
  logic [CNT_W-1:0] perf_branch_q, perf_branch_d;

  always_comb begin
    load_cause    = (state_q == S_LOAD) || (accept && (hit_a || hit_b));
    branch_cause  = (state_q == S_BRANCH)
                    || (state_q == S_IDLE && !hit_a && !hit_b && br);
    perf_load_d   = perf_load_q;
    perf_branch_d = perf_branch_q;
    if (stall && load_cause && perf_load_q != '1)
      perf_load_d = perf_load_q + 1'b1;
    if (stall && branch_cause && perf_branch_q != '1)
      perf_branch_d = perf_branch_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_load_q   <= '0;
      perf_branch_q <= '0;
    end else begin
      perf_load_q   <= perf_load_d;
      perf_branch_q <= perf_branch_d;
    end
  end

  assign perf_load_stalls   = perf_load_q;
  assign perf_branch_stalls = perf_branch_q;
`else
  assign perf_load_stalls   = '0;
  assign perf_branch_stalls = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: three differently configured controllers share one stimulus stream
// and are checked against a stall-budget reference model.
module tb_hazard_stall_ctrl;

  localparam int N = 3;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  // dut0: L=3 B=2 Z=1 ; dut1: L=1 B=2 Z=1 ; dut2: L=2 B=3 Z=0 CNT_W=2
  int unsigned       l_cyc[N] = '{3, 1, 2};
  int unsigned       b_cyc[N] = '{2, 2, 3};
  bit                z_ex[N]  = '{1'b1, 1'b1, 1'b0};
  longint unsigned   cmax[N]  = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd3};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_ex_mem_read = 1'b0;
  logic [4:0]  id_ex_rt = '0;
  logic        ex_mem_mem_read = 1'b0;
  logic [4:0]  ex_mem_rt = '0;
  logic [31:0] if_id_instr = '0;

  logic        hp[N], hi[N], bs[N];
  logic [1:0]  ss[N];
  logic [31:0] pl0, pb0, pl1, pb1;
  logic [1:0]  pl2, pb2;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .INSTR_W(32), .LOAD_STALL_CYCLES(3),
    .BRANCH_STALL_CYCLES(2), .ZERO_REG_EXEMPT(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt), .if_id_instr(if_id_instr),
    .hold_pc(hp[0]), .hold_if_id(hi[0]), .bubble_sel(bs[0]), .stall_state(ss[0]),
    .perf_load_stalls(pl0), .perf_branch_stalls(pb0));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .INSTR_W(32), .LOAD_STALL_CYCLES(1),
    .BRANCH_STALL_CYCLES(2), .ZERO_REG_EXEMPT(1'b1), .CNT_W(32)) dut1 (
    .clk(clk), .rst(rst), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt), .if_id_instr(if_id_instr),
    .hold_pc(hp[1]), .hold_if_id(hi[1]), .bubble_sel(bs[1]), .stall_state(ss[1]),
    .perf_load_stalls(pl1), .perf_branch_stalls(pb1));

  hazard_stall_ctrl #(.REG_ADDR_W(5), .INSTR_W(32), .LOAD_STALL_CYCLES(2),
    .BRANCH_STALL_CYCLES(3), .ZERO_REG_EXEMPT(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rt(ex_mem_rt), .if_id_instr(if_id_instr),
    .hold_pc(hp[2]), .hold_if_id(hi[2]), .bubble_sel(bs[2]), .stall_state(ss[2]),
    .perf_load_stalls(pl2), .perf_branch_stalls(pb2));

  typedef struct packed {
    logic        h;
    logic [1:0]  st;
    logic [31:0] pl;
    logic [31:0] pb;
  } exp_t;

  exp_t sb[N][$];

  int total = 0;
  int bad   = 0;

  // Reference model: remaining stall budget, its cause, and a one-cycle branch shadow.
  int unsigned     blk[N];
  bit              kbr[N];
  bit              rel[N];
  longint unsigned mpl[N], mpb[N];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t actual=%0h expected=%0h", nm, i, $time, act, expv);
    end
  endtask

  task automatic step(input bit r, input bit mra, input logic [4:0] rta,
                      input bit mrb, input logic [4:0] rtb, input logic [31:0] ins);
    exp_t        e;
    logic [4:0]  rs, rt;
    logic [5:0]  op;
    bit          ha, hb, isb, stall, isbr, was_rel;
    @(posedge clk);
    #1;
    rst = r; id_ex_mem_read = mra; id_ex_rt = rta;
    ex_mem_mem_read = mrb; ex_mem_rt = rtb; if_id_instr = ins;
    rs = ins[25:21]; rt = ins[20:16]; op = ins[31:26];
    for (int i = 0; i < N; i++) begin
      e = '0;
      if (r) begin
        blk[i] = 0; kbr[i] = 0; rel[i] = 0; mpl[i] = 0; mpb[i] = 0;
      end else begin
        stall = 0; isbr = 0;
        e.st = (blk[i] > 0) ? (kbr[i] ? 2'd2 : 2'd1) : (rel[i] ? 2'd3 : 2'd0);
        e.pl = 32'(mpl[i]);
        e.pb = 32'(mpb[i]);
        if (blk[i] > 0) begin
          stall = 1; isbr = kbr[i];
          blk[i]--;
          if (blk[i] == 0 && kbr[i]) rel[i] = 1;
        end else begin
          was_rel = rel[i]; rel[i] = 0;
          ha  = mra && (rta == rs || rta == rt) && !(z_ex[i] && rta == 0);
          hb  = (l_cyc[i] >= 2) && mrb && (rtb == rs || rtb == rt) && !(z_ex[i] && rtb == 0);
          isb = (op == 6'd4) || (op == 6'd5);
          if (ha) begin
            stall = 1; blk[i] = l_cyc[i] - 1; kbr[i] = 0;
          end else if (hb) begin
            stall = 1; blk[i] = l_cyc[i] - 2; kbr[i] = 0;
          end else if (isb && !was_rel) begin
            stall = 1; isbr = 1; blk[i] = b_cyc[i] - 1; kbr[i] = 1;
            if (blk[i] == 0) rel[i] = 1;
          end
        end
        e.h = stall;
        if (PERF_ON && stall) begin
          if (isbr) begin if (mpb[i] < cmax[i]) mpb[i]++; end
          else      begin if (mpl[i] < cmax[i]) mpl[i]++; end
        end
      end
      sb[i].push_back(e);
    end
  endtask

  task automatic nop(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 5'd0, 0, 5'd0, mk(6'd0, 5'd3, 5'd4));
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] apl, apb;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (sb[i].size() > 0) begin
          e = sb[i].pop_front();
          case (i)
            0:       begin apl = pl0; apb = pb0; end
            1:       begin apl = pl1; apb = pb1; end
            default: begin apl = {30'd0, pl2}; apb = {30'd0, pb2}; end
          endcase
          chk("hold_pc",     i, {31'd0, hp[i]}, {31'd0, e.h});
          chk("hold_if_id",  i, {31'd0, hi[i]}, {31'd0, e.h});
          chk("bubble_sel",  i, {31'd0, bs[i]}, {31'd0, e.h});
          chk("stall_state", i, {30'd0, ss[i]}, {30'd0, e.st});
          chk("perf_load",   i, apl, e.pl);
          chk("perf_branch", i, apb, e.pb);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [4:0] regs[4];
    logic [5:0] ops[5];
    regs = '{5'd0, 5'd1, 5'd8, 5'd31};
    ops  = '{6'd0, 6'd4, 6'd5, 6'd6, 6'h23};

    step(1, 0, 5'd0, 0, 5'd0, '0);
    step(1, 0, 5'd0, 0, 5'd0, '0);
    nop(1);
    // ID/EX load-use on rs, then on rt
    step(0, 1, 5'd8, 0, 5'd0, mk(6'd0, 5'd8, 5'd9));
    nop(4);
    step(0, 1, 5'd9, 0, 5'd0, mk(6'd0, 5'd8, 5'd9));
    nop(4);
    // load into r0: exempt on dut0/dut1, not on dut2
    step(0, 1, 5'd0, 0, 5'd0, mk(6'd0, 5'd0, 5'd3));
    nop(4);
    // EX/MEM-only hit
    step(0, 0, 5'd0, 1, 5'd8, mk(6'd0, 5'd3, 5'd8));
    nop(4);
    // beq held in IF/ID across its stall and release
    for (int k = 0; k < 4; k++) step(0, 0, 5'd0, 0, 5'd0, mk(6'd4, 5'd1, 5'd2));
    nop(3);
    // load-use and bne together, bne stays in IF/ID after the load moves on
    step(0, 1, 5'd5, 0, 5'd0, mk(6'd5, 5'd5, 5'd6));
    for (int k = 0; k < 5; k++) step(0, 0, 5'd0, 0, 5'd0, mk(6'd5, 5'd5, 5'd6));
    nop(4);
    // reset asserted in the second branch-stall cycle, with hazards still on the inputs
    step(0, 0, 5'd0, 0, 5'd0, mk(6'd4, 5'd1, 5'd2));
    step(1, 1, 5'd1, 0, 5'd0, mk(6'd4, 5'd1, 5'd2));
    nop(4);
    // repeated load stalls to drive the 2-bit counters into saturation
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 5'd8, 0, 5'd0, mk(6'd0, 5'd8, 5'd9));
      nop(3);
    end
    for (int k = 0; k < 600; k++) begin
      step(0, ($urandom_range(0, 2) != 0), regs[$urandom_range(0, 3)],
           ($urandom_range(0, 2) != 0), regs[$urandom_range(0, 3)],
           mk(ops[$urandom_range(0, 4)], regs[$urandom_range(0, 3)],
              regs[$urandom_range(0, 3)]));
    end
    nop(2);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("sb_drained", i, 32'(sb[i].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
